ccsds123_image_arbiter: RTL and testbench

CCSDS123_IMAGE_ARBITER -- requirements
Module: ccsds123_image_arbiter

---
 rtl/ccsds123_image_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_ccsds123_image_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccsds123_image_arbiter.sv
// ---------------------------------------------------------------------------
// ccsds123_image_arbiter
//
// Purpose:
//   Shares one CCSDS-123 compressor input stream between two sample sources.
//   A source is granted a whole image: exactly BEATS accepted beats, where
//   BEATS = NX*NY*NZ/PIPELINES. The grant is never changed part way through
//   an image. Each grant pushes the source id into a small tag FIFO. The
//   compressor output (mon_tvalid & mon_tlast) pops that FIFO, so tag_id
//   always names the source of the oldest image still inside the compressor.
//   A new image is refused while the tag FIFO is full.
//
// Configuration macro:
//   CCSDS123_ARB_FIXED_PRIO_EN - when defined, source 0 wins every contention.
//                                When undefined, contention is round-robin.
//
// Ports:
//   clk, areset           single clock, asynchronous active-high reset
//   s0_tdata/tvalid/tready source 0 AXI-Stream slave (PIPELINES*D bits)
//   s1_tdata/tvalid/tready source 1 AXI-Stream slave (PIPELINES*D bits)
//   m_tdata/tvalid/tready  AXI-Stream master towards the compressor input
//   mon_tvalid, mon_tlast  compressor output handshake, observed only
//   tag_id, tag_valid      source of the oldest in-flight image, FIFO non-empty
//   busy                   high while an image transfer is in progress
//   err_underflow          sticky: an image end was seen with no tag queued
// ---------------------------------------------------------------------------
module ccsds123_image_arbiter #(
  parameter int PIPELINES = 4,
  parameter int D         = 16,
  parameter int NX        = 16,
  parameter int NY        = 16,
  parameter int NZ        = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [PIPELINES*D-1:0] s0_tdata,
  input  logic                   s0_tvalid,
  output logic                   s0_tready,
  input  logic [PIPELINES*D-1:0] s1_tdata,
  input  logic                   s1_tvalid,
  output logic                   s1_tready,
  output logic [PIPELINES*D-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  input  logic                   mon_tvalid,
  input  logic                   mon_tlast,
  output logic                   tag_id,
  output logic                   tag_valid,
  output logic                   busy,
  output logic                   err_underflow
);

  localparam int BEATS = (NX * NY * NZ) / PIPELINES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(TAG_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(TAG_DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             lastGnt_q, lastGnt_d;
  logic [CNT_W-1:0] beatCnt_q, beatCnt_d;
  logic             errUnderflow_q, errUnderflow_d;

  logic             tagMem_q [TAG_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic tagFull;
  logic tagEmpty;
  logic tagPush;
  logic tagPopReq;
  logic tagPopOk;
  logic grantSrc;
  logic contendWinner;
  logic selValid;
  logic beatFire;

  // Winner when both sources request in the same IDLE cycle.
`ifdef CCSDS123_ARB_FIXED_PRIO_EN
  assign contendWinner = 1'b0;
`else
  assign contendWinner = ~lastGnt_q;
`endif

  assign tagFull  = (occ_q == OCC_FULL);
  assign tagEmpty = (occ_q == '0);

  // The data path is a plain mux on the grant register so it stays
  // combinational; in IDLE it simply shows the last granted source.
  assign m_tdata  = sel_q ? s1_tdata : s0_tdata;
  assign selValid = sel_q ? s1_tvalid : s0_tvalid;
  assign beatFire = (state_q == ACTIVE) && selValid && m_tready;

  assign busy          = (state_q == ACTIVE);
  assign err_underflow = errUnderflow_q;
  assign tag_valid     = ~tagEmpty;
  assign tag_id        = tagEmpty ? 1'b0 : tagMem_q[rdPtr_q];

  // Grant / transfer FSM: picks a source in IDLE, then streams exactly
  // BEATS handshakes from it before going back to IDLE.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    lastGnt_d = lastGnt_q;
    beatCnt_d = beatCnt_q;
    tagPush   = 1'b0;
    grantSrc  = 1'b0;
    m_tvalid  = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if ((s0_tvalid || s1_tvalid) && !tagFull) begin
          if (s0_tvalid && s1_tvalid) begin
            grantSrc = contendWinner;
          end else begin
            grantSrc = s1_tvalid;
          end
          sel_d     = grantSrc;
          lastGnt_d = grantSrc;
          beatCnt_d = '0;
          tagPush   = 1'b1;
          state_d   = ACTIVE;
        end
      end

      ACTIVE: begin
        m_tvalid  = selValid;
        s0_tready = ~sel_q & m_tready;
        s1_tready = sel_q & m_tready;
        if (beatFire) begin
          if (beatCnt_q == LAST_BEAT) begin
            beatCnt_d = '0;
            state_d   = IDLE;
          end else begin
            beatCnt_d = beatCnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tag FIFO bookkeeping. A pop on an empty FIFO is dropped and latched
  // as an underflow; a grant is never issued while full, so a push always
  // has room even when it coincides with a pop.
  always_comb begin
    tagPopReq      = mon_tvalid & mon_tlast;
    tagPopOk       = tagPopReq & ~tagEmpty;
    errUnderflow_d = errUnderflow_q | (tagPopReq & tagEmpty);
    wrPtr_d        = wrPtr_q;
    rdPtr_d        = rdPtr_q;
    occ_d          = occ_q;

    if (tagPush) begin
      wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + 1'b1;
    end
    if (tagPopOk) begin
      rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + 1'b1;
    end

    unique case ({tagPush, tagPopOk})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Control state registers. Reset drops any half-transferred image and
  // restores round-robin so source 0 wins the first contention.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q        <= IDLE;
      sel_q          <= 1'b0;
      lastGnt_q      <= 1'b1;
      beatCnt_q      <= '0;
      errUnderflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      lastGnt_q      <= lastGnt_d;
      beatCnt_q      <= beatCnt_d;
      errUnderflow_q <= errUnderflow_d;
    end
  end

  // Tag FIFO storage and pointers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tagMem_q[i] <= 1'b0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      occ_q   <= occ_d;
      if (tagPush) begin
        tagMem_q[wrPtr_q] <= grantSrc;
      end
    end
  end

endmodule

// File: tb/tb_ccsds123_image_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ccsds123_image_arbiter
//
// Self-checking bench for ccsds123_image_arbiter with a 4-beat image
// (PIPELINES=4, NX=4, NY=2, NZ=2) and a 4-deep tag FIFO. Each source drives
// a constant word that identifies it; the expected word of every beat is
// queued when the stimulus is set up and compared as the compressor side
// accepts it.
// ---------------------------------------------------------------------------
module tb_ccsds123_image_arbiter;

  localparam int PIPELINES = 4;
  localparam int D         = 16;
  localparam int W         = PIPELINES * D;

  localparam logic [W-1:0] S0_DATA = 64'hA003_A002_A001_A000;
  localparam logic [W-1:0] S1_DATA = 64'hB003_B002_B001_B000;

  logic         clk;
  logic         areset;
  logic [W-1:0] s0_tdata;
  logic         s0_tvalid;
  logic         s0_tready;
  logic [W-1:0] s1_tdata;
  logic         s1_tvalid;
  logic         s1_tready;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         mon_tvalid;
  logic         mon_tlast;
  logic         tag_id;
  logic         tag_valid;
  logic         busy;
  logic         err_underflow;

  int checkCount = 0;
  int errorCount = 0;

  logic [W-1:0] sb[$];
  logic         expSrc[5];

  ccsds123_image_arbiter #(
    .PIPELINES(PIPELINES),
    .D(D),
    .NX(4),
    .NY(2),
    .NZ(2),
    .TAG_DEPTH(4)
  ) dut (
    .clk(clk),
    .areset(areset),
    .s0_tdata(s0_tdata),
    .s0_tvalid(s0_tvalid),
    .s0_tready(s0_tready),
    .s1_tdata(s1_tdata),
    .s1_tvalid(s1_tvalid),
    .s1_tready(s1_tready),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .mon_tvalid(mon_tvalid),
    .mon_tlast(mon_tlast),
    .tag_id(tag_id),
    .tag_valid(tag_valid),
    .busy(busy),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Sets the handshake inputs; mon drives both mon_tvalid and mon_tlast.
  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic rdy, input logic mon);
    s0_tvalid  = v0;
    s1_tvalid  = v1;
    m_tready   = rdy;
    mon_tvalid = mon;
    mon_tlast  = mon;
  endtask

  task automatic pushImage(input logic src, input int beats);
    for (int b = 0; b < beats; b++) begin
      sb.push_back(src ? S1_DATA : S0_DATA);
    end
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, ".m_tvalid"},  m_tvalid,      '0);
    checkOutput({pfx, ".s0_tready"}, s0_tready,     '0);
    checkOutput({pfx, ".s1_tready"}, s1_tready,     '0);
    checkOutput({pfx, ".tag_valid"}, tag_valid,     '0);
    checkOutput({pfx, ".tag_id"},    tag_id,        '0);
    checkOutput({pfx, ".busy"},      busy,          '0);
    checkOutput({pfx, ".err"},       err_underflow, '0);
  endtask

  // Every accepted beat on the compressor side consumes one expected word.
  always @(negedge clk) begin
    if (!areset && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedBeat", 1, 0);
      end else begin
        checkOutput("beatData", m_tdata, sb.pop_front());
      end
    end
  end

  initial begin
`ifdef CCSDS123_ARB_FIXED_PRIO_EN
    expSrc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    expSrc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    s0_tdata = S0_DATA;
    s1_tdata = S1_DATA;
    applyStimulus(0, 0, 0, 0);
    areset = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1 areset = 1'b0;

    // Both sources always valid: four images, one IDLE cycle between them,
    // then the fifth is held off because the tag FIFO is full.
    for (int img = 0; img < 4; img++) begin
      pushImage(expSrc[img], 4);
    end
    applyStimulus(1, 1, 1, 0);
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("busy.c%0d", k), busy,
                  ((k % 5) != 0) && (k < 20));
      checkOutput($sformatf("mvalid.c%0d", k), m_tvalid,
                  ((k % 5) != 0) && (k < 20));
    end
    checkOutput("fullTagValid", tag_valid, 1);
    checkOutput("fullTagId", tag_id, expSrc[0]);
    checkOutput("fourImagesDone", sb.size(), 0);

    // One image end frees a slot; the fifth grant follows one cycle later.
    pushImage(expSrc[4], 4);
    applyStimulus(1, 1, 1, 1);
    @(posedge clk);
    #1 applyStimulus(1, 1, 1, 0);
    @(negedge clk);
    checkOutput("popBusy", busy, 0);
    checkOutput("popTagId", tag_id, expSrc[1]);
    @(posedge clk);
    @(negedge clk);
    checkOutput("fifthBusy", busy, 1);
    checkOutput("fifthMvalid", m_tvalid, 1);
    repeat (4) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("blockedBusy.%0d", k), busy, 0);
      checkOutput($sformatf("blockedMvalid.%0d", k), m_tvalid, 0);
      @(posedge clk);
    end
    #1 applyStimulus(0, 0, 1, 0);
    checkOutput("fifthImageDone", sb.size(), 0);

    // Drain the tag FIFO; sources come out in grant order.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("drainValid.%0d", i), tag_valid, 1);
      checkOutput($sformatf("drainTagId.%0d", i), tag_id, expSrc[i]);
      applyStimulus(0, 0, 1, 1);
      @(posedge clk);
      #1 applyStimulus(0, 0, 1, 0);
    end
    @(negedge clk);
    checkOutput("drainedValid", tag_valid, 0);
    checkOutput("drainedErr", err_underflow, 0);

    // Image end with nothing queued: sticky underflow.
    applyStimulus(0, 0, 1, 1);
    @(posedge clk);
    #1 applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    checkOutput("underflowSet", err_underflow, 1);
    checkOutput("underflowTagValid", tag_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("underflowSticky", err_underflow, 1);
    checkOutput("underflowTagValid2", tag_valid, 0);

    // Source 0 alone with m_tready toggling: 4 beats over 7 cycles.
    pushImage(1'b0, 4);
    applyStimulus(1, 0, 0, 0);
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      #1 m_tready = ((i % 2) == 0);
      @(negedge clk);
      checkOutput($sformatf("toggleS1Ready.%0d", i), s1_tready, 0);
      checkOutput($sformatf("toggleBusy.%0d", i), busy, 1);
      @(posedge clk);
    end
    #1 applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    checkOutput("toggleBusyDrop", busy, 0);
    checkOutput("toggleImageDone", sb.size(), 0);

    // Reset two beats into an image, then a clean restart.
    pushImage(1'b0, 2);
    applyStimulus(1, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1 areset = 1'b1;
    #1 checkResetOutputs("midReset");
    @(negedge clk);
    checkOutput("abortedBeats", sb.size(), 0);
    @(posedge clk);
    #1 areset = 1'b0;
    pushImage(1'b0, 4);
    applyStimulus(1, 1, 1, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("restartBusy", busy, 1);
    checkOutput("restartS0Ready", s0_tready, 1);
    checkOutput("restartS1Ready", s1_tready, 0);
    repeat (4) @(posedge clk);
    #1 applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    checkOutput("restartBusyDrop", busy, 0);
    checkOutput("restartImageDone", sb.size(), 0);
    checkOutput("restartTagValid", tag_valid, 1);
    checkOutput("restartTagId", tag_id, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
